// File: rtl/vector_stroke_gen_if.sv
// Command and beam-output bundle for the vector stroke generator.
// The master drives segment commands; the slave returns beam position and status.
`timescale 1ns/1ps

interface vector_stroke_gen_if #(
    parameter int CH_WIDTH = 8
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [CH_WIDTH-1:0] cmd_x;
    logic [CH_WIDTH-1:0] cmd_y;
    logic                cmd_beam;
    logic                cmd_jump;
    logic [CH_WIDTH-1:0] x_ch;
    logic [CH_WIDTH-1:0] y_ch;
    logic                beam;
    logic                busy;
    logic                seg_done;

    modport master (
        output cmd_valid, cmd_x, cmd_y, cmd_beam, cmd_jump,
        input  cmd_ready, x_ch, y_ch, beam, busy, seg_done
    );

    modport slave (
        input  cmd_valid, cmd_x, cmd_y, cmd_beam, cmd_jump,
        output cmd_ready, x_ch, y_ch, beam, busy, seg_done
    );
endinterface

// File: rtl/vector_stroke_gen.sv
// Vector display stroke generator: walks the beam from its current position to a
// commanded endpoint with Bresenham steps paced by a programmable divider.
`timescale 1ns/1ps

module vector_stroke_gen #(
    parameter int CH_WIDTH  = 8,
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [DIV_WIDTH-1:0] step_div,
    vector_stroke_gen_if.slave   bus
);
    localparam int EW = CH_WIDTH + 2;
    localparam logic [CH_WIDTH-1:0]  CH_ZERO  = {CH_WIDTH{1'b0}};
    localparam logic [CH_WIDTH-1:0]  CH_ONE   = {{(CH_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DIV_WIDTH-1:0] DIV_ZERO = {DIV_WIDTH{1'b0}};
    localparam logic [DIV_WIDTH-1:0] DIV_ONE  = {{(DIV_WIDTH-1){1'b0}}, 1'b1};
    localparam logic signed [EW-1:0] ERR_ZERO = {EW{1'b0}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        DRAW  = 2'd2
    } state_e;

    function automatic logic signed [EW-1:0] abs_delta(
        input logic [CH_WIDTH-1:0] a,
        input logic [CH_WIDTH-1:0] b
    );
        logic [CH_WIDTH-1:0] mag;
        if (a >= b) begin
            mag = a - b;
        end else begin
            mag = b - a;
        end
        return $signed({2'b00, mag});
    endfunction

    function automatic logic [CH_WIDTH-1:0] step_coord(
        input logic [CH_WIDTH-1:0] c,
        input logic                neg
    );
        return neg ? (c - CH_ONE) : (c + CH_ONE);
    endfunction

    state_e                 state_q, state_d;
    logic [CH_WIDTH-1:0]    tgt_x_q, tgt_x_d;
    logic [CH_WIDTH-1:0]    tgt_y_q, tgt_y_d;
    logic                   jump_q, jump_d;
    logic                   beam_cmd_q, beam_cmd_d;
    logic signed [EW-1:0]   dx_q, dx_d;
    logic signed [EW-1:0]   dy_q, dy_d;
    logic signed [EW-1:0]   err_q, err_d;
    logic                   sx_neg_q, sx_neg_d;
    logic                   sy_neg_q, sy_neg_d;
    logic [DIV_WIDTH-1:0]   div_q, div_d;
    logic [CH_WIDTH-1:0]    x_q, x_d;
    logic [CH_WIDTH-1:0]    y_q, y_d;
    logic                   beam_q, beam_d;
    logic                   seg_done_q, seg_done_d;

    logic                   cmd_ready_s;
    logic                   accept_s;
    logic                   tick_s;
    logic                   at_target_s;
    logic signed [EW-1:0]   e2_s;
    logic signed [EW-1:0]   dx_mag_s;
    logic signed [EW-1:0]   dy_mag_s;

    assign cmd_ready_s = (state_q == IDLE) & enable & rst;
    assign accept_s    = bus.cmd_valid & cmd_ready_s;
    // >= rather than == so a step_div lowered below the running count ticks at once
    assign tick_s      = (div_q >= step_div);
    assign at_target_s = (x_q == tgt_x_q) && (y_q == tgt_y_q);
    assign e2_s        = {err_q[EW-2:0], 1'b0};
    assign dx_mag_s    = abs_delta(tgt_x_q, x_q);
    assign dy_mag_s    = abs_delta(tgt_y_q, y_q);

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state decode; enable low freezes the sequence
    always_comb begin
        state_d = state_q;
        if (enable) begin
            case (state_q)
                IDLE: begin
                    if (accept_s) state_d = SETUP;
                    else          state_d = IDLE;
                end
                SETUP: begin
                    if (jump_q) state_d = IDLE;
                    else        state_d = DRAW;
                end
                DRAW: begin
                    if (tick_s && at_target_s) state_d = IDLE;
                    else                       state_d = DRAW;
                end
                default: state_d = IDLE;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Datapath next values: command capture, line setup, divider and Bresenham step
    always_comb begin
        tgt_x_d    = tgt_x_q;
        tgt_y_d    = tgt_y_q;
        jump_d     = jump_q;
        beam_cmd_d = beam_cmd_q;
        dx_d       = dx_q;
        dy_d       = dy_q;
        err_d      = err_q;
        sx_neg_d   = sx_neg_q;
        sy_neg_d   = sy_neg_q;
        div_d      = div_q;
        x_d        = x_q;
        y_d        = y_q;
        beam_d     = beam_q;
        seg_done_d = 1'b0;
        if (enable) begin
            case (state_q)
                IDLE: begin
                    if (accept_s) begin
                        tgt_x_d    = bus.cmd_x;
                        tgt_y_d    = bus.cmd_y;
                        jump_d     = bus.cmd_jump;
                        beam_cmd_d = bus.cmd_beam;
                    end else begin
                        tgt_x_d    = tgt_x_q;
                    end
                end
                SETUP: begin
                    dx_d     = dx_mag_s;
                    dy_d     = ERR_ZERO - dy_mag_s;
                    err_d    = dx_mag_s - dy_mag_s;
                    sx_neg_d = (tgt_x_q < x_q);
                    sy_neg_d = (tgt_y_q < y_q);
                    if (jump_q) begin
                        x_d        = tgt_x_q;
                        y_d        = tgt_y_q;
                        beam_d     = 1'b0;
                        seg_done_d = 1'b1;
                    end else begin
                        beam_d = beam_cmd_q;
                        div_d  = DIV_ZERO;
                    end
                end
                DRAW: begin
                    if (!tick_s) begin
                        div_d = div_q + DIV_ONE;
                    end else if (at_target_s) begin
                        div_d      = DIV_ZERO;
                        beam_d     = 1'b0;
                        seg_done_d = 1'b1;
                    end else begin
                        div_d = DIV_ZERO;
                        if (e2_s >= dy_q) begin
                            err_d = err_d + dy_q;
                            x_d   = step_coord(x_q, sx_neg_q);
                        end else begin
                            x_d   = x_q;
                        end
                        if (e2_s <= dx_q) begin
                            err_d = err_d + dx_q;
                            y_d   = step_coord(y_q, sy_neg_q);
                        end else begin
                            y_d   = y_q;
                        end
                    end
                end
                default: begin
                    beam_d = 1'b0;
                end
            endcase
        end else begin
            seg_done_d = 1'b0;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tgt_x_q    <= CH_ZERO;
            tgt_y_q    <= CH_ZERO;
            jump_q     <= 1'b0;
            beam_cmd_q <= 1'b0;
            dx_q       <= ERR_ZERO;
            dy_q       <= ERR_ZERO;
            err_q      <= ERR_ZERO;
            sx_neg_q   <= 1'b0;
            sy_neg_q   <= 1'b0;
            div_q      <= DIV_ZERO;
            x_q        <= CH_ZERO;
            y_q        <= CH_ZERO;
            beam_q     <= 1'b0;
            seg_done_q <= 1'b0;
        end else begin
            tgt_x_q    <= tgt_x_d;
            tgt_y_q    <= tgt_y_d;
            jump_q     <= jump_d;
            beam_cmd_q <= beam_cmd_d;
            dx_q       <= dx_d;
            dy_q       <= dy_d;
            err_q      <= err_d;
            sx_neg_q   <= sx_neg_d;
            sy_neg_q   <= sy_neg_d;
            div_q      <= div_d;
            x_q        <= x_d;
            y_q        <= y_d;
            beam_q     <= beam_d;
            seg_done_q <= seg_done_d;
        end
    end

    // Output drive from registered state
    always_comb begin
        bus.cmd_ready = cmd_ready_s;
        bus.x_ch      = x_q;
        bus.y_ch      = y_q;
        bus.beam      = beam_q;
        bus.busy      = (state_q != IDLE);
        bus.seg_done  = seg_done_q;
    end

endmodule

// File: doc/vector_stroke_gen.md
VECTOR_STROKE_GEN -- requirements
Module: vector_stroke_gen

Interface
REQ-001 Parameter CH_WIDTH, default 8, SHALL set the coordinate width of the X/Y output channels and command coordinates.
REQ-002 Parameter DIV_WIDTH, default 16, SHALL set the width of the step-rate divider.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 enable  input  1  SHALL be a global run enable; low freezes the divider, position and FSM.
REQ-006 step_div  input  DIV_WIDTH  SHALL set the step period to step_div+1 clocks.
REQ-007 cmd_valid  input  1  SHALL signal that a segment command is present.
REQ-008 cmd_ready  output  1  SHALL equal (state==IDLE) & enable & rst.
REQ-009 cmd_x, cmd_y  input  CH_WIDTH each  SHALL give the unsigned segment endpoint.
REQ-010 cmd_beam  input  1  SHALL select beam on (1, draw) or blanked (0, move) for the segment.
REQ-011 cmd_jump  input  1  SHALL request an immediate blanked reposition, with no stepping.
REQ-012 x_ch, y_ch  output  CH_WIDTH each  SHALL carry the registered beam position.
REQ-013 beam  output  1  SHALL carry the registered beam-on (Z) signal.
REQ-014 busy  output  1  SHALL be high whenever state != IDLE.
REQ-015 seg_done  output  1  SHALL give a one-clock pulse when a segment or jump completes.

Function
REQ-016 The FSM SHALL have states IDLE, SETUP and DRAW; a command SHALL be accepted only on a clock where cmd_valid & cmd_ready, with IDLE->SETUP.
REQ-017 SETUP (1 clock) SHALL latch the target and compute dx=|x1-x0|, dy=-|y1-y0|, sx/sy=+-1 and err=dx+dy, where x0/y0 = current x_ch/y_ch.
REQ-018 err and its intermediates SHALL be signed CH_WIDTH+2 bits; no overflow is permitted at full-scale deltas.
REQ-019 SETUP with cmd_jump=1 SHALL load x_ch/y_ch with the target, force beam=0, pulse seg_done and return to IDLE; cmd_beam SHALL be ignored.
REQ-020 SETUP with cmd_jump=0 SHALL set beam=cmd_beam, clear the divider to 0, and enter DRAW.
REQ-021 In DRAW, the divider SHALL count 0..step_div and raise a tick on the clock where count==step_div, then wrap to 0; the first tick SHALL fall on the (step_div+1)th DRAW clock.
REQ-022 On a tick, if position != target, the block SHALL take one Bresenham step:
- e2=2*err
- if e2>=dy: err+=dy, x+=sx
- if e2<=dx: err+=dx, y+=sy
- both conditions in the same tick move the beam diagonally.
REQ-023 On a tick with position==target, the block SHALL pulse seg_done, set beam=0 and return to IDLE.
REQ-024 A segment of N=max(|dx|,|dy|) steps SHALL raise seg_done exactly 1+(N+1)*(step_div+1) clocks after the accepting edge.
REQ-025 A zero-length segment with cmd_beam=1 SHALL produce a dot: beam high for step_div+1 clocks, then seg_done.
REQ-026 Position SHALL never overshoot the target or wrap past 0 or 2^CH_WIDTH-1.
REQ-027 With enable low, the divider, err, position, beam and state SHALL all hold; a held cmd_valid SHALL not be accepted.
REQ-028 While busy, cmd_valid SHALL be ignored; a command held valid SHALL be accepted on the first IDLE clock after seg_done, which allows back-to-back segments.
REQ-029 A step_div change during DRAW SHALL take effect from the next divider comparison.

Reset
REQ-030 rst low SHALL immediately force:
- x_ch=0, y_ch=0
- beam=0, busy=0, seg_done=0, cmd_ready=0
- divider=0, err=0
- state=IDLE.
REQ-031 Reset asserted mid-DRAW SHALL abort the segment without a seg_done pulse; after release the block SHALL start in IDLE at position (0,0).

Verification
REQ-032 step_div=0, draw to (5,2) from (0,0) -> steps (1,0),(2,1),(3,1),(4,2),(5,2), beam=1 throughout, seg_done 7 clocks after the accepting edge, then beam=0.
REQ-033 step_div=3, draw to (0,0) from (0,0) -> beam high for 4 clocks, seg_done 5 clocks after the accepting edge.
REQ-034 CH_WIDTH=8, jump to (255,255), then draw to (0,0) with step_div=0 -> x=y decrement by 1 for 255 ticks, no wrap, seg_done after 257 clocks.
REQ-035 enable pulled low for 10 clocks mid-segment -> outputs frozen for those 10 clocks, total latency grows by exactly 10 clocks.
REQ-036 Reset asserted at step 3 of the segment to (5,2) -> outputs zero asynchronously, no seg_done, cmd_ready=1 on the first clock after release.
REQ-037 Two commands presented back-to-back with cmd_valid held -> second accepted on the clock after seg_done, and segments join continuously at the shared endpoint.
